// File: rtl/uart_tx_fifo_if.sv
`timescale 1ns/1ps
// Producer-side bus of the UART transmitter: byte strobe in, queue status out.
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 16
) ();
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_full;
  logic          tx_empty;
  logic [CW-1:0] tx_count;
  logic          tx_overflow;
  logic          tx_busy;

  modport master (
    output tx_data, tx_start,
    input  tx_full, tx_empty, tx_count, tx_overflow, tx_busy
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_full, tx_empty, tx_count, tx_overflow, tx_busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// UART transmitter with a byte FIFO in front of a configurable serialiser.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit period
// DATA  | DATA_BITS data bits, LSB first
// PAR   | parity bit, only when PARITY != 0
// STOP  | STOP_BITS stop bits (high); chains to START
module uart_tx_fifo #(
  parameter int FREQ_IN    = 12_000_000,
  parameter int FREQ_OUT   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          hclk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus,
  output logic          tx
);
  localparam int DIV = FREQ_IN / FREQ_OUT;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0]    DATA_MASK = 8'hFF >> (8 - DATA_BITS);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter set");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          baud_tc;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, ovf_q;
  logic          push, pop;
  logic [7:0]    rd_data;

  // A write with the queue full is dropped, even if a pop frees a slot at the same edge.
  assign push    = bus.tx_start & ~full_q;
  assign rd_data = mem[rd_ptr_q];
  assign baud_tc = (baud_q == BAUD_LAST);

  // Queue storage; only the pointers need reset, they define which entries are valid.
  always_ff @(posedge hclk) begin
    if (push) mem[wr_ptr_q] <= bus.tx_data;
  end

  // Occupancy after this edge's push and pop.
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // Pointers, occupancy, registered flags and the overflow pulse.
  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(FIFO_DEPTH));
      empty_q <= (count_d == '0);
      ovf_q   <= bus.tx_start & full_q;
    end
  end

  // Frame sequencing and the line value for the next cycle; counters restart on state entry.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (baud_tc) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY != 0) ? PAR : STOP;
            bit_d   = '0;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
          end
        end
      end
      PAR: begin
        if (baud_tc) begin
          state_d = STOP;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (baud_tc) begin
          baud_d = '0;
          bit_d  = '0;
          if (bit_q == STOP_LAST) begin
            if (!empty_q) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      shreg_d = rd_data;
      par_d   = (^(rd_data & DATA_MASK)) ^ (PARITY == 1);
    end
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PAR:     tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  // FSM and serialiser registers; tx is registered so the line is glitch-free.
  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx              = tx_q;
  assign bus.tx_full     = full_q;
  assign bus.tx_empty    = empty_q;
  assign bus.tx_count    = count_q;
  assign bus.tx_overflow = ovf_q;
  assign bus.tx_busy     = (state_q != IDLE) | ~empty_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Bench for uart_tx_fifo: four instances with different frame formats,
// a queue-and-frame-position reference model and a per-cycle compare.
module tb_uart_tx_fifo;
  localparam int N = 4;

  logic hclk;
  logic rst;
  logic chk_en;
  int   n_cmp;
  int   n_err;
  int   cyc;

  logic [N-1:0] st;
  logic [7:0]   dt [N];
  logic [N-1:0] tx_w, busy_w, full_w, empty_w, ovf_w;
  logic [4:0]   cnt_w [N];
  logic [31:0]  cap_v [N];

  int div_p [N] = '{2, 2, 2, 1250};
  int db_p  [N] = '{8, 7, 7, 8};
  int par_p [N] = '{0, 2, 1, 0};
  int sb_p  [N] = '{1, 2, 2, 1};
  int dep_p [N] = '{4, 4, 4, 16};

  uart_tx_fifo_if #(.FIFO_DEPTH(4))  bus0 ();
  uart_tx_fifo_if #(.FIFO_DEPTH(4))  bus1 ();
  uart_tx_fifo_if #(.FIFO_DEPTH(4))  bus2 ();
  uart_tx_fifo_if #(.FIFO_DEPTH(16)) bus3 ();

  uart_tx_fifo #(.FREQ_IN(100), .FREQ_OUT(50), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(4)) dut0 (.hclk(hclk), .rst(rst), .bus(bus0), .tx(tx_w[0]));
  uart_tx_fifo #(.FREQ_IN(100), .FREQ_OUT(50), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2),
                 .FIFO_DEPTH(4)) dut1 (.hclk(hclk), .rst(rst), .bus(bus1), .tx(tx_w[1]));
  uart_tx_fifo #(.FREQ_IN(100), .FREQ_OUT(50), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
                 .FIFO_DEPTH(4)) dut2 (.hclk(hclk), .rst(rst), .bus(bus2), .tx(tx_w[2]));
  uart_tx_fifo dut3 (.hclk(hclk), .rst(rst), .bus(bus3), .tx(tx_w[3]));

  assign bus0.tx_start = st[0];  assign bus0.tx_data = dt[0];
  assign bus1.tx_start = st[1];  assign bus1.tx_data = dt[1];
  assign bus2.tx_start = st[2];  assign bus2.tx_data = dt[2];
  assign bus3.tx_start = st[3];  assign bus3.tx_data = dt[3];

  assign busy_w  = {bus3.tx_busy, bus2.tx_busy, bus1.tx_busy, bus0.tx_busy};
  assign full_w  = {bus3.tx_full, bus2.tx_full, bus1.tx_full, bus0.tx_full};
  assign empty_w = {bus3.tx_empty, bus2.tx_empty, bus1.tx_empty, bus0.tx_empty};
  assign ovf_w   = {bus3.tx_overflow, bus2.tx_overflow, bus1.tx_overflow, bus0.tx_overflow};
  assign cnt_w[0] = 5'(bus0.tx_count);
  assign cnt_w[1] = 5'(bus1.tx_count);
  assign cnt_w[2] = 5'(bus2.tx_count);
  assign cnt_w[3] = bus3.tx_count;

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial forever begin
    @(posedge hclk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  logic [7:0]   m_mem [N][16];
  int           m_cnt [N];
  int           m_rd  [N];
  int           m_pos [N];
  logic [7:0]   m_cur [N];
  logic [N-1:0] m_act, m_tx, m_ovf;

  function automatic int flen(input int d);
    return (1 + db_p[d] + ((par_p[d] != 0) ? 1 : 0) + sb_p[d]) * div_p[d];
  endfunction

  // Bit k of the frame carrying byte b: start, data LSB first, optional parity, stop.
  function automatic logic fbit(input int d, input logic [7:0] b, input int k);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) if (i < db_p[d]) p = p ^ b[i];
    if (k == 0) return 1'b0;
    if (k <= db_p[d]) return b[k-1];
    if (par_p[d] != 0 && k == db_p[d] + 1) return (par_p[d] == 2) ? p : ~p;
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge hclk or posedge rst);
    if (rst) begin
      for (int d = 0; d < N; d++) begin
        m_cnt[d] = 0; m_rd[d] = 0; m_pos[d] = 0;
        m_act[d] = 1'b0; m_tx[d] = 1'b1; m_ovf[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < N; d++) begin
        bit was_full;
        was_full = (m_cnt[d] == dep_p[d]);
        if (m_act[d]) begin
          m_pos[d]++;
          if (m_pos[d] >= flen(d)) m_act[d] = 1'b0;
        end
        if (!m_act[d] && m_cnt[d] > 0) begin
          m_cur[d] = m_mem[d][m_rd[d]];
          m_rd[d]  = (m_rd[d] + 1) % dep_p[d];
          m_cnt[d]--;
          m_act[d] = 1'b1;
          m_pos[d] = 0;
        end
        if (st[d] && !was_full) begin
          m_mem[d][(m_rd[d] + m_cnt[d]) % dep_p[d]] = dt[d];
          m_cnt[d]++;
        end
        m_ovf[d] = st[d] && was_full;
        m_tx[d]  = m_act[d] ? fbit(d, m_cur[d], m_pos[d] / div_p[d]) : 1'b1;
      end
    end
  end

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 20)
        $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge hclk);
    if (chk_en) begin
      for (int d = 0; d < N; d++) begin
        chk("line", d, tx_w[d], m_tx[d]);
        chk("busy", d, busy_w[d], m_act[d] || m_cnt[d] > 0);
        chk("count", d, cnt_w[d], m_cnt[d]);
        chk("full", d, full_w[d], m_cnt[d] == dep_p[d]);
        chk("empty", d, empty_w[d], m_cnt[d] == 0);
        chk("overflow", d, ovf_w[d], m_ovf[d]);
      end
    end
  end

  task automatic capture_all(input int n);
    for (int d = 0; d < N; d++) cap_v[d] = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge hclk);
      for (int d = 0; d < N; d++) cap_v[d][i] = tx_w[d];
    end
  endtask

  task automatic wait_idle(input int d, input int budget);
    int n = 0;
    while (busy_w[d] && n < budget) begin
      @(negedge hclk);
      n++;
    end
    chk("idle_timeout", d, busy_w[d], 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int k, bad, t0, len, ntr;
    logic prev;
    int tr [8];
    int exp_tr [5] = '{2500, 3750, 5000, 10000, 11250};

    rst = 1'b0; chk_en = 1'b0; n_cmp = 0; n_err = 0; cyc = 0; st = '0;
    for (int d = 0; d < N; d++) dt[d] = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(negedge hclk);
    chk("rst_tx", 0, tx_w[0], 1);
    chk("rst_busy", 0, busy_w[0], 0);
    chk("rst_empty", 0, empty_w[0], 1);
    chk("rst_full", 0, full_w[0], 0);
    chk("rst_count", 0, cnt_w[0], 0);
    chk("rst_ovf", 0, ovf_w[0], 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge hclk);

    // 8N1, 0x61
    st[0] = 1'b1; dt[0] = 8'h61;
    @(negedge hclk);
    st[0] = 1'b0;
    chk("t1_tx_before_fall", 0, tx_w[0], 1);
    chk("t1_busy_at_write", 0, busy_w[0], 1);
    chk("t1_empty_at_write", 0, empty_w[0], 0);
    capture_all(20);
    chk("t1_frame", 0, cap_v[0], 32'h000CF00C);
    chk("t1_busy_last", 0, busy_w[0], 1);
    @(negedge hclk);
    chk("t1_busy_drop", 0, busy_w[0], 0);

    // 7 data bits, even and odd parity, 2 stop bits, 0x61
    st[1] = 1'b1; st[2] = 1'b1; dt[1] = 8'h61; dt[2] = 8'h61;
    @(negedge hclk);
    st[1] = 1'b0; st[2] = 1'b0;
    capture_all(22);
    chk("t2_even_frame", 1, cap_v[1], 32'h003FF00C);
    chk("t2_odd_frame", 2, cap_v[2], 32'h003CF00C);
    chk("t2_busy_last", 1, busy_w[1], 1);
    @(negedge hclk);
    chk("t2_busy_drop", 1, busy_w[1], 0);
    chk("t2_busy_drop", 2, busy_w[2], 0);

    // 'a'..'f' on consecutive cycles into a 4-deep queue
    for (int i = 0; i < 6; i++) begin
      st[0] = 1'b1; dt[0] = 8'(8'h61 + i);
      @(negedge hclk);
      if (i == 4) begin
        chk("t3_full", 0, full_w[0], 1);
        chk("t3_count_full", 0, cnt_w[0], 4);
      end
      if (i == 5) begin
        chk("t3_ovf_pulse", 0, ovf_w[0], 1);
        chk("t3_count_hold", 0, cnt_w[0], 4);
      end
    end
    st[0] = 1'b0;
    @(negedge hclk);
    chk("t3_ovf_end", 0, ovf_w[0], 0);
    k = 6;
    while (busy_w[0] && k < 400) begin
      @(negedge hclk);
      k++;
    end
    chk("t3_busy_run", 0, k, 101);
    wait_idle(0, 50);

    // write landing on the same edge as a pop from a full queue
    for (int i = 0; i < 5; i++) begin
      st[0] = 1'b1; dt[0] = 8'(8'h41 + i);
      @(negedge hclk);
    end
    st[0] = 1'b0;
    repeat (16) @(negedge hclk);
    chk("t4_count_before", 0, cnt_w[0], 4);
    st[0] = 1'b1; dt[0] = 8'h7E;
    @(negedge hclk);
    st[0] = 1'b0;
    chk("t4_count_after", 0, cnt_w[0], 3);
    chk("t4_ovf", 0, ovf_w[0], 1);
    chk("t4_full_after", 0, full_w[0], 0);
    wait_idle(0, 300);

    // reset during data bit 0 of the second frame
    for (int i = 0; i < 5; i++) begin
      st[0] = 1'b1; dt[0] = 8'(8'h30 + 2 * i);
      @(negedge hclk);
    end
    st[0] = 1'b0;
    repeat (19) @(negedge hclk);
    chk("t5_count_pre", 0, cnt_w[0], 3);
    chk("t5_tx_pre", 0, tx_w[0], 0);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_tx", 0, tx_w[0], 1);
    chk("t5_rst_count", 0, cnt_w[0], 0);
    chk("t5_rst_busy", 0, busy_w[0], 0);
    chk("t5_rst_empty", 0, empty_w[0], 1);
    @(negedge hclk);
    @(negedge hclk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge hclk);
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
    end
    chk("t5_no_resume", 0, bad, 0);
    st[0] = 1'b1; dt[0] = 8'h55;
    @(negedge hclk);
    st[0] = 1'b0;
    wait_idle(0, 100);

    // default parameters, 0x7A
    st[3] = 1'b1; dt[3] = 8'h7A;
    @(negedge hclk);
    st[3] = 1'b0;
    k = 0;
    while (tx_w[3] !== 1'b0 && k < 10) begin
      @(negedge hclk);
      k++;
    end
    chk("t6_fall_latency", 3, k, 1);
    t0 = cyc; prev = 1'b0; ntr = 0;
    while (busy_w[3] && (cyc - t0) < 13000) begin
      @(negedge hclk);
      if (tx_w[3] !== prev) begin
        if (ntr < 8) tr[ntr] = cyc - t0;
        ntr++;
        prev = tx_w[3];
      end
    end
    len = cyc - t0;
    chk("t6_frame_len", 3, len, 12500);
    chk("t6_edge_count", 3, ntr, 5);
    for (int i = 0; i < 5; i++) chk("t6_edge_pos", 3, tr[i], exp_tr[i]);

    repeat (2) @(negedge hclk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO; the next generation of the fixed 8N1 transmitter used in the board examples. It accepts bytes from a producer such as the ASCII character generator and queues up to FIFO_DEPTH of them. It serialises each byte with a configurable data width, parity and stop-bit count at FREQ_IN/FREQ_OUT clocks per bit. tx_busy can gate the producer's pulse generator exactly as the 8N1 block's busy flag does today.

## Interface
- FREQ_IN, 12e6: hclk frequency in Hz (100 in SIM builds).
- FREQ_OUT, 9600: baud rate in Hz (50 in SIM builds).
- DATA_BITS, 8: data bits per frame, legal 5..8.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 16: entries, power of two, ≥2.

- hclk  in  1  system clock.
- rst  in  1  reset; asynchronous and active-high.
- tx_data  in  8  byte to queue; only bits [DATA_BITS-1:0] are transmitted.
- tx_start  in  1  write strobe; one byte queued per hclk cycle while high.
- tx_full  out  1  FIFO holds FIFO_DEPTH entries.
- tx_empty  out  1  FIFO holds 0 entries.
- tx_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx_overflow  out  1  one-cycle pulse when a write is dropped.
- tx_busy  out  1  frame in progress or FIFO non-empty.
- tx  out  1  serial line, idle high.

## Operation
- Bit period DIV = FREQ_IN/FREQ_OUT (integer truncation). DIV < 2, or any illegal parameter value, fails elaboration.
- Write: tx_start high at an edge with tx_full low (value before the edge) pushes tx_data. With tx_full high, the byte is dropped and tx_overflow pulses high for the next cycle. This holds even if a pop occurs at the same edge.
- Simultaneous push and pop: both take effect and tx_count is unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: tx=1. If FIFO non-empty, pop into the shift register, go to START.
  - START: tx=0 for DIV cycles, then go to DATA.
  - DATA: DATA_BITS bits, LSB first, DIV cycles each. Then go to PAR if PARITY≠0, else to STOP.
  - PAR: one bit for DIV cycles. Even: XOR of the data bits. Odd: its inverse.
  - STOP: tx=1 for STOP_BITS×DIV cycles.
- End of the last stop cycle: if FIFO non-empty, pop and go to START with no idle gap; otherwise go to IDLE.
- The bit counter and baud counter restart at 0 on every state entry. The baud counter is log2-sized for DIV-1.
- tx_busy = (state≠IDLE) | ~tx_empty.

## Timing
- Reset values (asynchronous, effective immediately, including mid-frame):
  - tx=1, tx_busy=0, tx_empty=1, tx_full=0, tx_count=0, tx_overflow=0.
  - State IDLE; FIFO pointers cleared and contents discarded.
  - A truncated frame is not resumed.
- tx is a register. With the FIFO empty and state IDLE, tx_start high at edge N gives:
  - tx_empty low after edge N.
  - Pop at edge N+1, where tx falls.
  - tx_busy high from edge N.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)×DIV cycles, exactly.
- Back-to-back frames: the next start bit begins on the cycle after the final stop-bit cycle.
- tx_full, tx_empty and tx_count are registered and update on the edge of the push or pop.

## Test plan
- SIM params (DIV=2), 8N1: write 0x61 once. tx = 0,1,0,0,0,0,1,1,0,1, each bit 2 cycles, falling 1 cycle after the write. tx_busy drops after 20 cycles of frame.
- DATA_BITS=7, PARITY=2, STOP_BITS=2: write 0x61. Data bits 1,0,0,0,0,1,1, parity 1, two stop bits; 22-cycle frame. Repeat with PARITY=1: parity 0.
- FIFO_DEPTH=4: write 'a'..'f' on 6 consecutive cycles.
  - 'a' pops at edge 1, so writes 'b'..'e' fill the FIFO and tx_full rises.
  - The 'f' write pulses tx_overflow once.
  - The line carries a,b,c,d,e back-to-back with no idle gaps.
- Full FIFO with a write coinciding with the pop edge: the write is dropped (overflow pulse) and tx_count goes 4→3.
- Assert rst mid-data-bit of frame 2 with 3 queued. tx=1 immediately, tx_count=0, tx_busy=0. After release, no frame is sent until a new write.
- Default params (DIV=1250): one frame of 0x7A measures 12500 cycles; each bit edge is at a multiple of 1250 from the start.
